jogo_unidade_controle: RTL and testbench

Control unit for the memory-sequence game (16 rounds, 4 buttons). It sequences the game datapath: it clears and advances the address and round counters, loads the play register, and reads the comparator and end-of-sequence flags. It runs an internal play-timeout timer and drives the `pronto`, `ganhou` and `perdeu` result outputs. It sits beside the datapath inside `circuito_exp6`; `db_estado` feeds the 7-segment debug decoder.

---
 rtl/jogo_unidade_controle.sv | 168 ++++++++++++++++
 tb/tb_jogo_unidade_controle.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jogo_unidade_controle.sv
// Purpose: Moore control FSM for the 16-round memory game; optional play timeout via JOGO_TIMEOUT_EN.
// Latency: outputs decode from the state register only; a press is registered one edge after detection.
// Backpressure: none; iniciar is honoured only in INICIAL and FIM_* states, held buttons count once.
module jogo_unidade_controle #(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim_e,
    input  logic       fim_r,
    output logic       zera_e,
    output logic       conta_e,
    output logic       zera_r,
    output logic       conta_r,
    output logic       registra_r,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        INICIA_RODADA = 4'h2,
        ESPERA        = 4'h3,
        REGISTRA      = 4'h4,
        COMPARA       = 4'h5,
        PROX_JOGADA   = 4'h6,
        PROX_RODADA   = 4'h7,
        FIM_ACERTOU   = 4'hA,
        FIM_TIMEOUT   = 4'hD,
        FIM_ERROU     = 4'hE
    } estado_t;

    estado_t estado;
    estado_t proximo;
    logic    jogada_d;
    logic    pulso;

    // Edge detector: one pulse per button press, however long it is held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            jogada_d <= 1'b0;
        end else begin
            jogada_d <= jogada;
        end
    end

    assign pulso = jogada & ~jogada_d;

`ifdef JOGO_TIMEOUT_EN
    localparam logic [15:0] LIMITE = 16'(TIMEOUT_CICLOS - 1);

    logic [15:0] timer;
    logic        timeout;

    // Play timer: counts only while waiting for a press, saturates instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (estado != ESPERA) begin
            timer <= '0;
        end else if (timer != 16'hFFFF) begin
            timer <= timer + 16'd1;
        end
    end

    assign timeout = (estado == ESPERA) && (timer == LIMITE);
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state logic; unused codes fall back to INICIAL.
    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:       proximo = iniciar ? PREPARA : INICIAL;
            PREPARA:       proximo = INICIA_RODADA;
            INICIA_RODADA: proximo = ESPERA;
            ESPERA: begin
                // A press in the same cycle as the timeout still counts as a play.
                if (pulso) begin
                    proximo = REGISTRA;
`ifdef JOGO_TIMEOUT_EN
                end else if (timeout) begin
                    proximo = FIM_TIMEOUT;
`endif
                end else begin
                    proximo = ESPERA;
                end
            end
            REGISTRA:      proximo = COMPARA;
            COMPARA: begin
                if (!igual) begin
                    proximo = FIM_ERROU;
                end else if (!fim_e) begin
                    proximo = PROX_JOGADA;
                end else if (fim_r) begin
                    proximo = FIM_ACERTOU;
                end else begin
                    proximo = PROX_RODADA;
                end
            end
            PROX_JOGADA:   proximo = ESPERA;
            PROX_RODADA:   proximo = INICIA_RODADA;
            FIM_ACERTOU:   proximo = iniciar ? PREPARA : FIM_ACERTOU;
            FIM_ERROU:     proximo = iniciar ? PREPARA : FIM_ERROU;
`ifdef JOGO_TIMEOUT_EN
            FIM_TIMEOUT:   proximo = iniciar ? PREPARA : FIM_TIMEOUT;
`endif
            default:       proximo = INICIAL;
        endcase
    end

    // Moore output decode: every output is a function of the state alone.
    always_comb begin
        zera_e     = 1'b0;
        conta_e    = 1'b0;
        zera_r     = 1'b0;
        conta_r    = 1'b0;
        registra_r = 1'b0;
        pronto     = 1'b0;
        ganhou     = 1'b0;
        perdeu     = 1'b0;
        db_timeout = 1'b0;
        case (estado)
            PREPARA: begin
                zera_e = 1'b1;
                zera_r = 1'b1;
            end
            INICIA_RODADA: zera_e     = 1'b1;
            REGISTRA:      registra_r = 1'b1;
            PROX_JOGADA:   conta_e    = 1'b1;
            PROX_RODADA:   conta_r    = 1'b1;
            FIM_ACERTOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
`ifdef JOGO_TIMEOUT_EN
            FIM_TIMEOUT: begin
                pronto     = 1'b1;
                perdeu     = 1'b1;
                db_timeout = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_jogo_unidade_controle.sv
// Purpose: self-checking bench for jogo_unidade_controle with a small datapath model and state-change scoreboard.
// Latency: expected states are queued ahead of stimulus and checked as the DUT moves through them.
// Backpressure: none; every wait is bounded and expiry is reported as a failed check.
module tb_jogo_unidade_controle;

    localparam int T = 20;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fim_e;
    logic       fim_r;
    logic       zera_e, conta_e, zera_r, conta_r, registra_r;
    logic       pronto, ganhou, perdeu, db_timeout;
    logic [3:0] db_estado;

    jogo_unidade_controle #(.TIMEOUT_CICLOS(T)) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .jogada     (jogada),
        .igual      (igual),
        .fim_e      (fim_e),
        .fim_r      (fim_r),
        .zera_e     (zera_e),
        .conta_e    (conta_e),
        .zera_r     (zera_r),
        .conta_r    (conta_r),
        .registra_r (registra_r),
        .pronto     (pronto),
        .ganhou     (ganhou),
        .perdeu     (perdeu),
        .db_timeout (db_timeout),
        .db_estado  (db_estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [3:0] st;
        int         dcyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         passed = 0;
    int         total = 0;
    int         edges = 0;
    int         last_chg = 0;
    int         n_conta_r = 0;
    int         n_registra = 0;
    logic [3:0] prev_st = 4'h0;
    logic [3:0] addr = 4'h0;
    logic [3:0] rnd = 4'h0;
    logic       err_en = 1'b0;
    logic [8:0] outs_v;

    assign outs_v = {zera_e, conta_e, zera_r, conta_r, registra_r, pronto, ganhou, perdeu, db_timeout};

    // Datapath model: address/round counters, wrong play injected at round 2, play 1.
    always @(posedge clock) begin
        edges <= edges + 1;
        if (zera_e) addr <= 4'h0;
        else if (conta_e) addr <= addr + 4'h1;
        if (zera_r) rnd <= 4'h0;
        else if (conta_r) rnd <= rnd + 4'h1;
    end

    assign igual = !(err_en && rnd == 4'd2 && addr == 4'd1);
    assign fim_e = (addr == rnd);
    assign fim_r = (rnd == 4'd15);

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endfunction

    // Expected Moore outputs per state code.
    function automatic logic [8:0] exp_out(input logic [3:0] s);
        case (s)
            4'h1:    exp_out = 9'b101000000;
            4'h2:    exp_out = 9'b100000000;
            4'h4:    exp_out = 9'b000010000;
            4'h6:    exp_out = 9'b010000000;
            4'h7:    exp_out = 9'b000100000;
            4'hA:    exp_out = 9'b000001100;
            4'hE:    exp_out = 9'b000001010;
            4'hD:    exp_out = 9'b000001011;
            default: exp_out = 9'b000000000;
        endcase
    endfunction

    // Monitor: each state change pops one expectation and checks state, outputs and edge distance.
    always @(negedge clock) begin
        if (conta_r) n_conta_r++;
        if (registra_r) n_registra++;
        if (db_estado !== prev_st) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_state_change", 32'(db_estado), 32'(prev_st));
            end else begin
                mon_e = exp_q.pop_front();
                chk("state", 32'(db_estado), 32'(mon_e.st));
                chk("outputs", 32'(outs_v), 32'(exp_out(mon_e.st)));
                if (mon_e.dcyc != 0) chk("edges_to_state", 32'(edges - last_chg), 32'(mon_e.dcyc));
            end
            prev_st  = db_estado;
            last_chg = edges;
        end
    end

    task automatic tick;
        @(negedge clock);
        #1;
    endtask

    task automatic push(input logic [3:0] s, input int d);
        exp_q.push_back('{st: s, dcyc: d});
    endtask

    task automatic start_game;
        push(4'h1, 0);
        push(4'h2, 1);
        push(4'h3, 1);
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
    endtask

    task automatic wait_st(input logic [3:0] s, input string nm);
        int n = 0;
        while (db_estado !== s && n < 300) begin
            tick;
            n++;
        end
        chk(nm, 32'(db_estado), 32'(s));
    endtask

    task automatic press(input int hold);
        wait_st(4'h3, "wait_espera");
        jogada = 1'b1;
        repeat (hold) tick;
        jogada = 1'b0;
        tick;
    endtask

    task automatic drain;
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick;
            n++;
        end
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Expected state path for play j of round r with a correct play.
    task automatic exp_play(input int r, input int j);
        push(4'h4, 0);
        push(4'h5, 1);
        if (j < r) begin
            push(4'h6, 1);
            push(4'h3, 1);
        end else if (r < 15) begin
            push(4'h7, 1);
            push(4'h2, 1);
            push(4'h3, 1);
        end else begin
            push(4'hA, 1);
        end
    endtask

    initial begin
        int base;
        iniciar = 1'b0;
        jogada  = 1'b0;
        reset   = 1'b1;
        #1 reset = 1'b0;
        repeat (3) tick;
        chk("reset_state", 32'(db_estado), 32'h0);
        chk("reset_outputs", 32'(outs_v), 32'h0);
        reset = 1'b1;
        tick;

        // Full win: 136 correct presses over 16 rounds.
        start_game;
        for (int r = 0; r < 16; r++) begin
            for (int j = 0; j <= r; j++) begin
                exp_play(r, j);
                press(10);
            end
        end
        drain;
        chk("win_conta_r_count", 32'(n_conta_r), 32'd15);
        chk("win_registra_count", 32'(n_registra), 32'd136);
        chk("win_ganhou", 32'(ganhou), 32'd1);
        chk("win_perdeu", 32'(perdeu), 32'd0);

        // Wrong play at round 2, play 1, with the button held 50 cycles.
        err_en = 1'b1;
        start_game;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j <= r; j++) begin
                exp_play(r, j);
                press(10);
            end
        end
        exp_play(2, 0);
        press(10);
        push(4'h4, 0);
        push(4'h5, 1);
        push(4'hE, 1);
        base = n_registra;
        press(50);
        drain;
        chk("held_single_registra", 32'(n_registra - base), 32'd1);
        chk("err_state", 32'(db_estado), 32'hE);
        chk("err_pronto", 32'(pronto), 32'd1);
        chk("err_ganhou", 32'(ganhou), 32'd0);
        err_en = 1'b0;

        // Restart from FIM_ERROU.
        push(4'h1, 0);
        push(4'h2, 1);
        push(4'h3, 1);
        iniciar = 1'b1;
        @(posedge clock);
        #1;
        chk("restart_state", 32'(db_estado), 32'h1);
        chk("restart_zeras", 32'({zera_e, zera_r}), 32'b11);
        tick;
        iniciar = 1'b0;

        // Asynchronous reset in the middle of ESPERA.
        wait_st(4'h3, "espera_before_reset");
        repeat (3) tick;
        push(4'h0, 0);
        reset = 1'b0;
        #1;
        chk("async_reset_state", 32'(db_estado), 32'h0);
        chk("async_reset_outputs", 32'(outs_v), 32'h0);
        tick;
        tick;
        reset = 1'b1;
        repeat (5) tick;
        chk("idle_after_reset", 32'(db_estado), 32'h0);
        drain;

        // Timeout with no press.
        start_game;
`ifdef JOGO_TIMEOUT_EN
        push(4'hD, T);
        drain;
        chk("timeout_flag", 32'(db_timeout), 32'd1);
`else
        repeat (1000) tick;
        chk("no_timeout_state", 32'(db_estado), 32'h3);
        chk("no_timeout_flag", 32'(db_timeout), 32'd0);
        drain;
`endif

        // Press arriving in the same cycle as the timeout condition.
        push(4'h0, 0);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        start_game;
        wait_st(4'h3, "espera_before_race");
        repeat (T - 1) tick;
        push(4'h4, T);
        push(4'h5, 1);
        push(4'h7, 1);
        push(4'h2, 1);
        push(4'h3, 1);
`ifdef JOGO_TIMEOUT_EN
        push(4'hD, T);
`endif
        jogada = 1'b1;
        repeat (5) tick;
        jogada = 1'b0;
        drain;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
